// File: rtl/oc8051_ifetch_if.sv
// Fetch-side bundle: program-ROM read port plus the decoder handshake.
// master = fetch unit (drives rom_addr and captured op bytes),
// slave  = surrounding ROM/decoder (drives data, take, redirects).
interface oc8051_ifetch_if;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data1;
  logic [7:0]  rom_data2;
  logic [7:0]  rom_data3;
  logic        rom_ea_int;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic [7:0]  op3;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        op_take;
  logic [1:0]  op_len;
  logic        jmp_req;
  logic [15:0] jmp_addr;

  modport master (
    output rom_addr, op1, op2, op3, op_pc, op_valid,
    input  rom_data1, rom_data2, rom_data3, rom_ea_int,
    input  op_take, op_len, jmp_req, jmp_addr
  );

  modport slave (
    input  rom_addr, op1, op2, op3, op_pc, op_valid,
    output rom_data1, rom_data2, rom_data3, rom_ea_int,
    output op_take, op_len, jmp_req, jmp_addr
  );
endinterface

// File: rtl/oc8051_ifetch.sv
// Instruction fetch front-end: registered ROM address, 3-byte capture, valid/take hold.
// Latency: op_valid 2 clocks after rom_addr load (3 for external fetch when
// OC8051_IFETCH_EXT_WAIT_EN is defined); outputs frozen in HOLD until op_take or jmp_req.
module oc8051_ifetch #(
  parameter logic [15:0] RST_VEC = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  oc8051_ifetch_if.master bus
);

`ifdef OC8051_IFETCH_EXT_WAIT_EN
  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD, EXTWAIT} state_t;
`else
  typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD} state_t;
`endif

  state_t      state;
  logic [15:0] pc;
  logic [15:0] rom_addr_q;
  logic [7:0]  op1_q;
  logic [7:0]  op2_q;
  logic [7:0]  op3_q;
  logic [15:0] op_pc_q;
  logic        op_valid_q;
  logic [1:0]  eff_len;
  logic [15:0] pc_next;

  // A zero length from the decoder still has to make forward progress.
  assign eff_len = (bus.op_len == 2'b00) ? 2'd1 : bus.op_len;
  // Sequential advance, wraps modulo 2^16.
  assign pc_next = pc + {14'd0, eff_len};

  // Fetch sequencer: redirect beats everything but reset; captures happen only in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ISSUE;
      pc         <= RST_VEC;
      rom_addr_q <= RST_VEC;
      op_pc_q    <= RST_VEC;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      op3_q      <= 8'h00;
      op_valid_q <= 1'b0;
    end else if (bus.jmp_req) begin
      // Any in-flight ROM data is simply never captured.
      pc         <= bus.jmp_addr;
      rom_addr_q <= bus.jmp_addr;
      op_valid_q <= 1'b0;
      state      <= ISSUE;
    end else begin
      case (state)
        ISSUE: begin
`ifdef OC8051_IFETCH_EXT_WAIT_EN
          state <= bus.rom_ea_int ? CAPTURE : EXTWAIT;
`else
          state <= CAPTURE;
`endif
        end
`ifdef OC8051_IFETCH_EXT_WAIT_EN
        EXTWAIT: state <= CAPTURE;
`endif
        CAPTURE: begin
          op1_q      <= bus.rom_data1;
          op2_q      <= bus.rom_data2;
          op3_q      <= bus.rom_data3;
          op_pc_q    <= pc;
          op_valid_q <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          // op_take only matters here, i.e. while op_valid is high.
          if (bus.op_take) begin
            pc         <= pc_next;
            rom_addr_q <= pc_next;
            op_valid_q <= 1'b0;
            state      <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.op1      = op1_q;
  assign bus.op2      = op2_q;
  assign bus.op3      = op3_q;
  assign bus.op_pc    = op_pc_q;
  assign bus.op_valid = op_valid_q;

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed bench for oc8051_ifetch with a registered 3-byte ROM model.
module tb_oc8051_ifetch;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  oc8051_ifetch_if bus ();

  oc8051_ifetch #(.RST_VEC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data follows rom_addr by one edge, addr+1/+2 wrap.
  logic [7:0]  mem [0:65535];
  logic [15:0] a1;
  logic [15:0] a2;
  assign a1 = bus.rom_addr + 16'd1;
  assign a2 = bus.rom_addr + 16'd2;
  always_ff @(posedge clk) begin
    bus.rom_data1 <= mem[bus.rom_addr];
    bus.rom_data2 <= mem[a1];
    bus.rom_data3 <= mem[a2];
  end
  assign bus.rom_ea_int = (bus.rom_addr < 16'h0080);

  function automatic int exp_lat(input logic [15:0] a);
`ifdef OC8051_IFETCH_EXT_WAIT_EN
    return (a < 16'h0080) ? 2 : 3;
`else
    return (a == a) ? 2 : 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until op_valid is seen, bounded at 20.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.op_valid && n < 20);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.rom_addr, bus.op_pc, bus.op1, bus.op2, bus.op3, bus.op_valid} !== {16'h0000, 16'h0000, 24'h000000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%h pc=%h op=%h%h%h v=%b exp 0000/0000/000000/0", bus.rom_addr, bus.op_pc, bus.op1, bus.op2, bus.op3, bus.op_valid);
    end
    rst = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL reset_latency: got %0d exp 2", n);
    end
    checks++;
    if ({bus.op_pc, bus.op1, bus.op2, bus.op3} !== {16'h0000, 24'h752000}) begin
      errors++;
      $display("FAIL reset_first_op: got %h %h%h%h exp 0000 752000", bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_sequential();
    int n;
    bus.op_take = 1'b1; bus.op_len = 2'd3;
    tick();
    bus.op_take = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.op_valid} !== {16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL seq_take3_addr: got %h v=%b exp 0003 v=0", bus.rom_addr, bus.op_valid);
    end
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL seq_gap1: got %0d exp 2", n);
    end
    checks++;
    if ({bus.op_pc, bus.op1, bus.op2, bus.op3} !== {16'h0003, 24'hD20212}) begin
      errors++;
      $display("FAIL seq_op_0003: got %h %h%h%h exp 0003 D20212", bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
    // Outputs must stay frozen while nobody takes.
    repeat (3) tick();
    checks++;
    if ({bus.op_valid, bus.op_pc} !== {1'b1, 16'h0003}) begin
      errors++;
      $display("FAIL seq_hold: got v=%b pc=%h exp v=1 pc=0003", bus.op_valid, bus.op_pc);
    end
    bus.op_take = 1'b1; bus.op_len = 2'd2;
    tick();
    bus.op_take = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL seq_gap2: got %0d exp 2", n);
    end
    checks++;
    if ({bus.op_pc, bus.op1, bus.op2, bus.op3} !== {16'h0005, 24'h12000E}) begin
      errors++;
      $display("FAIL seq_op_0005: got %h %h%h%h exp 0005 12000E", bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_redirect_with_take();
    int n;
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h000E;
    bus.op_take = 1'b1; bus.op_len = 2'd3;
    tick();
    bus.jmp_req = 1'b0; bus.op_take = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.op_valid} !== {16'h000E, 1'b0}) begin
      errors++;
      $display("FAIL redir_addr: got %h v=%b exp 000E v=0", bus.rom_addr, bus.op_valid);
    end
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h000E, 24'h75800A}) begin
      errors++;
      $display("FAIL redir_op: got lat=%0d %h %h%h%h exp 2 000E 75800A", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_jump_in_capture();
    int n;
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0003;
    tick();
    bus.jmp_req = 1'b0;
    // In ISSUE now: a take here must be ignored.
    bus.op_take = 1'b1; bus.op_len = 2'd3;
    tick();
    bus.op_take = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.op_valid} !== {16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL take_ignored: got %h v=%b exp 0003 v=0", bus.rom_addr, bus.op_valid);
    end
    // In CAPTURE of 0003: redirect to 0008.
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0008;
    tick();
    bus.jmp_req = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.op_valid} !== {16'h0008, 1'b0}) begin
      errors++;
      $display("FAIL capjmp_discard: got %h v=%b exp 0008 v=0", bus.rom_addr, bus.op_valid);
    end
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h0008, 24'h852080}) begin
      errors++;
      $display("FAIL capjmp_op: got lat=%0d %h %h%h%h exp 2 0008 852080", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_wrap_len0();
    int n;
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'hFFFF;
    tick();
    bus.jmp_req = 1'b0;
    wait_valid(n);
    checks++;
    if ({n, bus.op_pc, bus.op1, bus.op2, bus.op3} !== {exp_lat(16'hFFFF), 16'hFFFF, 24'hAA7520}) begin
      errors++;
      $display("FAIL wrap_ffff: got lat=%0d %h %h%h%h exp %0d FFFF AA7520", n, bus.op_pc, bus.op1, bus.op2, bus.op3, exp_lat(16'hFFFF));
    end
    bus.op_take = 1'b1; bus.op_len = 2'd3;
    tick();
    bus.op_take = 1'b0;
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h0002, 24'h00D202}) begin
      errors++;
      $display("FAIL wrap_0002: got lat=%0d %h %h%h%h exp 2 0002 00D202", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
    bus.op_take = 1'b1; bus.op_len = 2'd0;
    tick();
    bus.op_take = 1'b0;
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h0003, 24'hD20212}) begin
      errors++;
      $display("FAIL len0_0003: got lat=%0d %h %h%h%h exp 2 0003 D20212", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_ext_wait();
    int n;
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0080;
    tick();
    bus.jmp_req = 1'b0;
    wait_valid(n);
    checks++;
    if ({n, bus.op_pc, bus.op1} !== {exp_lat(16'h0080), 16'h0080, 8'hE4}) begin
      errors++;
      $display("FAIL ext_0080: got lat=%0d %h %h exp %0d 0080 E4", n, bus.op_pc, bus.op1, exp_lat(16'h0080));
    end
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0010;
    tick();
    bus.jmp_req = 1'b0;
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h0010, 24'h0A0000}) begin
      errors++;
      $display("FAIL int_0010: got lat=%0d %h %h%h%h exp 2 0010 0A0000", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    // rst wins over a simultaneous redirect and take.
    rst = 1'b1;
    bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0040;
    bus.op_take = 1'b1; bus.op_len = 2'd2;
    tick();
    bus.jmp_req = 1'b0; bus.op_take = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.op_pc, bus.op1, bus.op2, bus.op3, bus.op_valid} !== {16'h0000, 16'h0000, 24'h000000, 1'b0}) begin
      errors++;
      $display("FAIL midreset_state: got addr=%h pc=%h op=%h%h%h v=%b exp 0000/0000/000000/0", bus.rom_addr, bus.op_pc, bus.op1, bus.op2, bus.op3, bus.op_valid);
    end
    rst = 1'b0;
    wait_valid(n);
    checks++;
    if ({n[7:0], bus.op_pc, bus.op1, bus.op2, bus.op3} !== {8'd2, 16'h0000, 24'h752000}) begin
      errors++;
      $display("FAIL midreset_op: got lat=%0d %h %h%h%h exp 2 0000 752000", n, bus.op_pc, bus.op1, bus.op2, bus.op3);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h75; mem[16'h0001] = 8'h20; mem[16'h0002] = 8'h00;
    mem[16'h0003] = 8'hD2; mem[16'h0004] = 8'h02; mem[16'h0005] = 8'h12;
    mem[16'h0006] = 8'h00; mem[16'h0007] = 8'h0E;
    mem[16'h0008] = 8'h85; mem[16'h0009] = 8'h20; mem[16'h000A] = 8'h80;
    mem[16'h000E] = 8'h75; mem[16'h000F] = 8'h80; mem[16'h0010] = 8'h0A;
    mem[16'h0080] = 8'hE4;
    mem[16'hFFFF] = 8'hAA;
    rst          = 1'b1;
    bus.op_take  = 1'b0;
    bus.op_len   = 2'd0;
    bus.jmp_req  = 1'b0;
    bus.jmp_addr = 16'h0000;

    test_reset();
    test_sequential();
    test_redirect_with_take();
    test_jump_in_capture();
    test_wrap_len0();
    test_ext_wait();
    test_reset_mid_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
